// File: rtl/lcdf_pkg.sv
// Shared game constants and enums for the trail generator and its consumers.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package lcdf_pkg;

   localparam int TRAIL_LEN = 41;                 // trail slots / output array depth
   localparam int LIFE_MAX  = 15;                 // life of a freshly spawned slot
   localparam int PLAYER_X  = 100;                // fixed screen x of the player
   localparam int PTR_W     = $clog2(TRAIL_LEN);  // write pointer width

   typedef enum logic [1:0] {
      MENU  = 2'b00,
      PLAY  = 2'b01,
      OVER  = 2'b10,
      PAUSE = 2'b11
   } gamemode_t;

   typedef enum logic [2:0] {
      CLEAR,
      RUN,
      HOLD,
      FADE,
      DONE
   } trail_state_t;

   // Ring pointer increment, wrapping TRAIL_LEN-1 -> 0.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(TRAIL_LEN - 1)) ? '0 : p + 1'b1;
   endfunction

endpackage

// File: rtl/player_trail_if.sv
// Bundles the game-logic inputs and the packed trail arrays of player_trail.
// Latency: n/a (wires only).
// Backpressure: none; tick is a one-cycle strobe, arrays are level outputs.
// Ports: tick, gamemode, player_y (master -> slave); trail_x/y/life (slave -> master).
interface player_trail_if;
   import lcdf_pkg::*;

   logic                            tick;
   gamemode_t                       gamemode;
   logic [8:0]                      player_y;
   logic [TRAIL_LEN-1:0][9:0]       trail_x;
   logic [TRAIL_LEN-1:0][8:0]       trail_y;
   logic [TRAIL_LEN-1:0][3:0]       trail_life;

   modport master (
      output tick, gamemode, player_y,
      input  trail_x, trail_y, trail_life
   );

   modport slave (
      input  tick, gamemode, player_y,
      output trail_x, trail_y, trail_life
   );
endinterface

// File: rtl/trail_slot.sv
// One trail particle register: spawn load, per-tick aging with left scroll.
// Latency: 1 cycle from clr/age_en/spawn_en to registered outputs.
// Backpressure: none; spawn_en has priority over aging of this slot.
// Ports: clk, rst_n, clr, age_en, spawn_en, spawn_y -> x, y, life.
module trail_slot
   import lcdf_pkg::*;
#(
   parameter int SCROLL = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       age_en,
   input  logic       spawn_en,
   input  logic [8:0] spawn_y,
   output logic [9:0] x,
   output logic [8:0] y,
   output logic [3:0] life
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x    <= '0;
         y    <= '0;
         life <= '0;
      end else if (clr) begin
         x    <= '0;
         y    <= '0;
         life <= '0;
      end else if (spawn_en) begin
         x    <= 10'(PLAYER_X);
         y    <= spawn_y;
         life <= 4'(LIFE_MAX);
      end else if (age_en && (life != 4'd0)) begin
         // A particle that would scroll past the left edge dies pinned at x=0.
         if (x < 10'(SCROLL)) begin
            x    <= '0;
            life <= '0;
         end else begin
            x    <= x - 10'(SCROLL);
            life <= life - 4'd1;
         end
      end
   end

endmodule

// File: rtl/player_trail.sv
// Player motion-trail generator: samples player_y into a ring of slots, ages/scrolls them per tick.
// Latency: tick update visible one cycle after tick (on the edge sampling tick); gamemode 00 clears next edge.
// Backpressure: none; every tick is a full update, back-to-back ticks accepted.
// Ports: clk, rst_n (async active-low), bus (player_trail_if.slave).
// Option: TRAIL_SKIP_STILL_EN suppresses a due spawn when player_y equals the last spawned y.
module player_trail
   import lcdf_pkg::*;
#(
   parameter int SPAWN_DIV = 2,
   parameter int SCROLL    = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   player_trail_if.slave     bus
);

   trail_state_t               state, state_nxt;
   logic [PTR_W-1:0]           wr_ptr;
   logic [3:0]                 spawn_cnt;
   logic                       all_dead;
   logic                       clr;
   logic                       run_tick;
   logic                       age_en;
   logic                       spawn_due;
   logic                       spawn_fire;
   logic [TRAIL_LEN-1:0][9:0]  slot_x;
   logic [TRAIL_LEN-1:0][8:0]  slot_y;
   logic [TRAIL_LEN-1:0][3:0]  slot_life;

   assign all_dead = ~|slot_life;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= CLEAR;
      else        state <= state_nxt;
   end

   // Transitions are resolved combinationally so a tick arriving with a
   // gamemode change is processed in the destination state.
   always_comb begin
      state_nxt = state;
      if (bus.gamemode == MENU) begin
         state_nxt = CLEAR;
      end else begin
         case (state)
            CLEAR: if (bus.tick && bus.gamemode == PLAY) state_nxt = RUN;
            RUN: begin
               if (bus.gamemode == PAUSE)     state_nxt = HOLD;
               else if (bus.gamemode == OVER) state_nxt = FADE;
            end
            HOLD: begin
               if (bus.gamemode == PLAY)      state_nxt = RUN;
               else if (bus.gamemode == OVER) state_nxt = FADE;
            end
            FADE:    if (all_dead) state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = CLEAR;
         endcase
      end
   end

   assign clr       = (state_nxt == CLEAR);
   assign run_tick  = bus.tick && (state_nxt == RUN);
   assign age_en    = bus.tick && ((state_nxt == RUN) || (state_nxt == FADE));
   assign spawn_due = run_tick && (spawn_cnt == 4'd0);

`ifdef TRAIL_SKIP_STILL_EN
   logic [8:0] last_y;

   assign spawn_fire = spawn_due && (bus.player_y != last_y);

   // 9'h1FF is outside the 0..479 range, so the first spawn always happens.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          last_y <= 9'h1FF;
      else if (clr)        last_y <= 9'h1FF;
      else if (spawn_fire) last_y <= bus.player_y;
   end
`else
   assign spawn_fire = spawn_due;
`endif

   // Held at zero throughout CLEAR, so entering RUN always starts at slot 0
   // with a spawn due; HOLD leaves both untouched so the phase resumes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         spawn_cnt <= '0;
      end else if (clr) begin
         wr_ptr    <= '0;
         spawn_cnt <= '0;
      end else begin
         if (run_tick)
            spawn_cnt <= (spawn_cnt == 4'(SPAWN_DIV - 1)) ? 4'd0 : spawn_cnt + 4'd1;
         if (spawn_fire)
            wr_ptr <= ptr_inc(wr_ptr);
      end
   end

   for (genvar i = 0; i < TRAIL_LEN; i++) begin : g_slot
      trail_slot #(
         .SCROLL (SCROLL)
      ) u_slot (
         .clk      (clk),
         .rst_n    (rst_n),
         .clr      (clr),
         .age_en   (age_en),
         .spawn_en (spawn_fire && (wr_ptr == PTR_W'(i))),
         .spawn_y  (bus.player_y),
         .x        (slot_x[i]),
         .y        (slot_y[i]),
         .life     (slot_life[i])
      );
   end

   assign bus.trail_x    = slot_x;
   assign bus.trail_y    = slot_y;
   assign bus.trail_life = slot_life;

endmodule

// File: tb/tb_player_trail.sv
// Randomized scoreboard bench for player_trail against a behavioural trail model.
// Latency: expected snapshot checked one clock after the driven inputs.
// Backpressure: n/a.
module tb_player_trail;
   import lcdf_pkg::*;

   localparam int SPAWN_DIV = 2;
   localparam int SCROLL    = 4;

   localparam int M_CLEAR = 0, M_RUN = 1, M_HOLD = 2, M_FADE = 3, M_DONE = 4;

   typedef struct {
      logic [TRAIL_LEN-1:0][9:0] x;
      logic [TRAIL_LEN-1:0][8:0] y;
      logic [TRAIL_LEN-1:0][3:0] l;
   } snap_t;

   logic clk;
   logic rst_n;
   player_trail_if bus();

   player_trail #(
      .SPAWN_DIV (SPAWN_DIV),
      .SCROLL    (SCROLL)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int    n_total  = 0;
   int    n_passed = 0;
   snap_t exp_q[$];

   // Behavioural model: plain particle list plus mode and spawn phase.
   int mx[TRAIL_LEN];
   int my[TRAIL_LEN];
   int ml[TRAIL_LEN];
   int mmode;
   int wp;
   int phase;
   int last_y;
   int cur_gm;
   int cur_y;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got no end, wanted completion");
      $fatal(1, "watchdog");
   end

   task automatic model_clear();
      for (int i = 0; i < TRAIL_LEN; i++) begin
         mx[i] = 0; my[i] = 0; ml[i] = 0;
      end
      wp     = 0;
      phase  = 0;
      last_y = 511;
      mmode  = M_CLEAR;
   endtask

   function automatic bit model_all_dead();
      for (int i = 0; i < TRAIL_LEN; i++)
         if (ml[i] != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_step(input bit tk, input int gm, input int py);
      bit spawn;
      if (gm == 0) mmode = M_CLEAR;
      else begin
         case (mmode)
            M_CLEAR: if (tk && gm == 1) mmode = M_RUN;
            M_RUN:   if (gm == 3) mmode = M_HOLD; else if (gm == 2) mmode = M_FADE;
            M_HOLD:  if (gm == 1) mmode = M_RUN;  else if (gm == 2) mmode = M_FADE;
            M_FADE:  if (model_all_dead()) mmode = M_DONE;
            default: ;
         endcase
      end
      if (mmode == M_CLEAR) begin
         model_clear();
      end else if (tk && (mmode == M_RUN || mmode == M_FADE)) begin
         spawn = (mmode == M_RUN) && (phase == 0);
`ifdef TRAIL_SKIP_STILL_EN
         if (py == last_y) spawn = 1'b0;
`endif
         if (mmode == M_RUN) phase = (phase + 1) % SPAWN_DIV;
         for (int i = 0; i < TRAIL_LEN; i++) begin
            if (spawn && i == wp) begin
               mx[i] = PLAYER_X; my[i] = py; ml[i] = LIFE_MAX;
            end else if (ml[i] > 0) begin
               if (mx[i] < SCROLL) begin
                  mx[i] = 0; ml[i] = 0;
               end else begin
                  mx[i] = mx[i] - SCROLL; ml[i] = ml[i] - 1;
               end
            end
         end
         if (spawn) begin
            wp     = (wp + 1) % TRAIL_LEN;
            last_y = py;
         end
      end
   endtask

   task automatic push_expected();
      snap_t s;
      for (int i = 0; i < TRAIL_LEN; i++) begin
         s.x[i] = 10'(mx[i]);
         s.y[i] = 9'(my[i]);
         s.l[i] = 4'(ml[i]);
      end
      exp_q.push_back(s);
   endtask

   // One clock of stimulus: drive at the falling edge, predict the next edge.
   task automatic cyc(input bit rst_a, input bit tk, input int gm, input int py);
      @(negedge clk);
      rst_n        = !rst_a;
      bus.tick     = tk;
      bus.gamemode = gamemode_t'(gm[1:0]);
      bus.player_y = 9'(py);
      cur_gm       = gm;
      cur_y        = py;
      if (rst_a) model_clear();
      else       model_step(tk, gm, py);
      push_expected();
   endtask

   task automatic chk(input string nm, input int got, input int want);
      n_total++;
      if (got == want) n_passed++;
      else $display("FAIL %s: got %0d, expected %0d", nm, got, want);
   endtask

   // Directed spot checks, taken just after the edge of the last cyc() call.
   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   // Monitor: compares every predicted snapshot against the registered outputs.
   initial begin
      snap_t e;
      int    bi;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            bi = -1;
            for (int i = TRAIL_LEN - 1; i >= 0; i--) if (bus.trail_x[i] !== e.x[i]) bi = i;
            n_total++;
            if (bi < 0) n_passed++;
            else $display("FAIL trail_x slot %0d at %0t: got %0d, expected %0d", bi, $time, bus.trail_x[bi], e.x[bi]);
            bi = -1;
            for (int i = TRAIL_LEN - 1; i >= 0; i--) if (bus.trail_y[i] !== e.y[i]) bi = i;
            n_total++;
            if (bi < 0) n_passed++;
            else $display("FAIL trail_y slot %0d at %0t: got %0d, expected %0d", bi, $time, bus.trail_y[bi], e.y[bi]);
            bi = -1;
            for (int i = TRAIL_LEN - 1; i >= 0; i--) if (bus.trail_life[i] !== e.l[i]) bi = i;
            n_total++;
            if (bi < 0) n_passed++;
            else $display("FAIL trail_life slot %0d at %0t: got %0d, expected %0d", bi, $time, bus.trail_life[bi], e.l[bi]);
         end
      end
   end

   initial begin
      int gm;
      int y;
      int r;
      rst_n        = 1'b0;
      bus.tick     = 1'b0;
      bus.gamemode = MENU;
      bus.player_y = '0;
      model_clear();

      repeat (3) cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);

      // First play tick spawns slot 0; then three more back-to-back ticks.
      cyc(0, 1, 1, 200);
`ifndef TRAIL_SKIP_STILL_EN
      settle();
      chk("first_spawn_x", int'(bus.trail_x[0]), 100);
      chk("first_spawn_y", int'(bus.trail_y[0]), 200);
      chk("first_spawn_life", int'(bus.trail_life[0]), 15);
      chk("first_spawn_slot1_life", int'(bus.trail_life[1]), 0);
`endif
      repeat (3) cyc(0, 1, 1, 200);
`ifndef TRAIL_SKIP_STILL_EN
      settle();
      chk("tick4_slot0_x", int'(bus.trail_x[0]), 88);
      chk("tick4_slot0_life", int'(bus.trail_life[0]), 12);
      chk("tick4_slot1_x", int'(bus.trail_x[1]), 96);
      chk("tick4_slot1_life", int'(bus.trail_life[1]), 14);
      chk("tick4_slot2_life", int'(bus.trail_life[2]), 0);
`endif

      // Pause with ticks, then resume: spawn phase continues into slot 2.
      repeat (10) cyc(0, 1, 3, 250);
`ifndef TRAIL_SKIP_STILL_EN
      settle();
      chk("pause_slot0_life", int'(bus.trail_life[0]), 12);
`endif
      cyc(0, 1, 1, 260);
`ifndef TRAIL_SKIP_STILL_EN
      settle();
      chk("resume_slot2_life", int'(bus.trail_life[2]), 15);
      chk("resume_slot2_y", int'(bus.trail_y[2]), 260);
`endif

      // Long play run: pointer wraps and overwrites the oldest slots.
      y = 100;
      for (int i = 0; i < 90; i++) begin
         if ($urandom_range(0, 1) == 1) y = $urandom_range(0, 479);
         cyc(0, 1, 1, y);
      end

      // Game over: ages out without spawning, then freezes in DONE.
      for (int i = 0; i < 25; i++) cyc(0, 1, 2, $urandom_range(0, 479));
      settle();
      chk("fade_all_dead", (bus.trail_life == '0) ? 1 : 0, 1);

      // Menu without a tick still clears.
      cyc(0, 0, 0, 5);

      // Still-player run: one spawn unless y changes (skip option only differs).
      for (int i = 0; i < 6; i++) cyc(0, 1, 1, 200);
      for (int i = 0; i < 3; i++) cyc(0, 1, 1, 201);
      cyc(0, 0, 0, 0);

      // Randomized mix with idle cycles and occasional asynchronous resets.
      y = 0;
      for (int i = 0; i < 1500; i++) begin
         r = $urandom_range(0, 99);
         if (r < 70)      gm = 1;
         else if (r < 80) gm = 3;
         else if (r < 94) gm = 2;
         else             gm = 0;
         if ($urandom_range(0, 1) == 1) y = $urandom_range(0, 479);
         if ($urandom_range(0, 99) == 0) cyc(1, 0, gm, y);
         else cyc(0, ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0, gm, y);
      end

      cyc(0, 0, 0, 0);
      repeat (4) @(negedge clk);
      n_total++;
      if (exp_q.size() == 0) n_passed++;
      else $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());

      $display("%0d/%0d checks passed", n_passed, n_total);
      $finish;
   end

endmodule
